// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and buffered memory results onto the register file write port; keeps a per-register busy scoreboard.
// Latency: ALU result written 1 cycle after acceptance; memory result written 2 cycles after its push into an empty FIFO.
// Backpressure: mem_ready low while the FIFO is full; ALU has none and starves the FIFO. WB_FORWARD_EN adds write-port forwarding.
module writeback_unit #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
`ifdef WB_FORWARD_EN
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data,
`endif
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_mem [FIFO_DEPTH];
    wb_entry_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // Ready comes from the registered count only; a same-cycle pop does not free a slot.
    assign fifo_empty = (count == '0);
    assign mem_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push       = mem_valid && mem_ready;
    assign pop        = !alu_valid && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wb_entry_t'{rd: mem_rd, data: mem_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic            sel_vld;
    logic            sel_from_mem;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        sel_vld      = 1'b0;
        sel_from_mem = 1'b0;
        sel_rd       = '0;
        sel_data     = '0;
        if (alu_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (!fifo_empty) begin
            sel_vld      = 1'b1;
            sel_from_mem = 1'b1;
            sel_rd       = head.rd;
            sel_data     = head.data;
        end
    end

    logic wb_from_mem;

    // x0 results are consumed but never raise reg_write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write   <= 1'b0;
            wb_from_mem <= 1'b0;
            rd          <= '0;
            write_data  <= '0;
        end else begin
            reg_write   <= sel_vld && (sel_rd != 5'd0);
            wb_from_mem <= sel_from_mem && (sel_rd != 5'd0);
            if (sel_vld) begin
                rd         <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

    logic [31:0] busy;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    assign issue_ready = ~busy[issue_rd];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) set_vec[issue_rd] = 1'b1;
        if (reg_write && wb_from_mem) clr_vec[rd] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-edge reissue keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd1_hit  = reg_write && (rd == rs1) && (rd != 5'd0);
    assign fwd2_hit  = reg_write && (rd == rs2) && (rd != 5'd0);
    assign fwd1_data = write_data;
    assign fwd2_data = write_data;
    assign rs1_busy  = busy[rs1] && !fwd1_hit;
    assign rs2_busy  = busy[rs2] && !fwd2_hit;
`else
    assign rs1_busy  = busy[rs1];
    assign rs2_busy  = busy[rs2];
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for writeback_unit with a queue-based reference model and a decoupled write-port monitor.
module tb_writeback_unit;
    localparam int XLEN       = 32;
    localparam int FIFO_DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
`ifdef WB_FORWARD_EN
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
`endif
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;

    writeback_unit #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_FORWARD_EN
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
`endif
        .reg_write(reg_write), .rd(rd), .write_data(write_data)
    );

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: memory results waiting, expected writes, busy set, in-flight write.
    wr_t         mq[$];
    wr_t         exp_q[$];
    logic [31:0] busy_m     = '0;
    logic        pend_clr   = 1'b0;
    logic [4:0]  pend_rd    = '0;
    logic        cur_vld    = 1'b0;
    logic [4:0]  cur_rd     = '0;
    logic [XLEN-1:0] cur_dat = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs, check the combinational view against the model, then advance the model.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] mdat,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic        rdy_m;
        logic        f1;
        logic        f2;
        logic        nxt_vld;
        logic        nxt_mem;
        logic [4:0]  nxt_rd;
        logic [XLEN-1:0] nxt_dat;
        logic [31:0] clr_mask;
        logic [31:0] set_mask;
        wr_t         e;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
        #1;
        rdy_m = (mq.size() < FIFO_DEPTH);
        f1 = 1'b0;
        f2 = 1'b0;
`ifdef WB_FORWARD_EN
        f1 = cur_vld && (cur_rd == r1);
        f2 = cur_vld && (cur_rd == r2);
        chk("fwd1_hit", fwd1_hit, f1);
        chk("fwd2_hit", fwd2_hit, f2);
        if (f1) chk("fwd1_data", fwd1_data, cur_dat);
        if (f2) chk("fwd2_data", fwd2_data, cur_dat);
`endif
        chk("mem_ready", mem_ready, rdy_m);
        chk("issue_ready", issue_ready, !busy_m[ird]);
        chk("rs1_busy", rs1_busy, busy_m[r1] && !f1);
        chk("rs2_busy", rs2_busy, busy_m[r2] && !f2);

        nxt_vld = 1'b0; nxt_mem = 1'b0; nxt_rd = '0; nxt_dat = '0;
        if (av) begin
            nxt_vld = (ard != 0); nxt_rd = ard; nxt_dat = adat;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            nxt_vld = (e.rd != 0); nxt_mem = nxt_vld; nxt_rd = e.rd; nxt_dat = e.data;
        end
        if (nxt_vld) exp_q.push_back(wr_t'{rd: nxt_rd, data: nxt_dat});
        if (mv && rdy_m) mq.push_back(wr_t'{rd: mrd, data: mdat});

        clr_mask = '0;
        set_mask = '0;
        if (pend_clr) clr_mask[pend_rd] = 1'b1;
        if (iv && !busy_m[ird] && ird != 0) set_mask[ird] = 1'b1;
        busy_m   = (busy_m & ~clr_mask) | set_mask;
        pend_clr = nxt_mem;
        pend_rd  = nxt_rd;
        cur_vld  = nxt_vld;
        cur_rd   = nxt_rd;
        cur_dat  = nxt_dat;
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Monitor: every write the DUT presents is matched against the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && reg_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: rd=%0d data=%0h, no write expected", rd, write_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", rd, e.rd);
                    chk("wb_data", write_data, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 7; rs1 = 7; rs2 = 3;
        #12;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_rd", rd, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_rs1_busy", rs1_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU path
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("alu_reg_write", reg_write, 1);
        chk("alu_rd", rd, 5);
        chk("alu_write_data", write_data, 32'hDEADBEEF);

        // ALU holds the port for 6 cycles while the FIFO fills with x10..x13
        for (int i = 0; i < 6; i++)
            cycle(1, 5'(20 + i), $urandom, (i < 4), 5'(10 + i), $urandom, 0, 0, 0, 0);
        idle(6, 0, 0);

        // Scoreboard set, query, and clear via a memory write
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 7, 7, 7);
        chk("sb_x7_busy", rs1_busy, 1);
        cycle(0, 0, 0, 1, 7, 32'h1234, 0, 7, 7, 7);
        idle(4, 7, 7);
        chk("sb_x7_cleared", rs1_busy, 0);

        // Memory result to x0 pops without a write
        cycle(0, 0, 0, 1, 0, 32'hAAAA5555, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("x0_no_write", reg_write, 0);

        // Issue x9 on the edge its earlier memory write clears it
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
        chk("collision_x9_busy", rs1_busy, 1);
        idle(3, 9, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        idle(10, 0, 0);
        chk("drain_empty", exp_q.size(), 0);

        // Reset in the middle of traffic with three results queued
        cycle(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
        for (int i = 0; i < 3; i++)
            cycle(1, 5'(3 + i), $urandom, 1, 5'(11 + i), $urandom, 0, 0, 12, 0);
        chk("pre_rst_fifo_entries", mq.size(), 3);
        @(negedge clk);
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        #1;
        mq.delete();
        exp_q.delete();
        busy_m = '0; pend_clr = 1'b0; cur_vld = 1'b0;
        chk("mid_rst_reg_write", reg_write, 0);
        chk("mid_rst_mem_ready", mem_ready, 1);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            chk("mid_rst_rs1_busy", rs1_busy, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(8, 12, 11);
        chk("post_rst_no_writes", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side front end of the 32×32 integer register file. Merges single-cycle ALU results and long-latency memory/multi-cycle results into the register file's single write port (`reg_write`, `rd`, `write_data`). Buffers memory results in a small FIFO and keeps a per-register busy scoreboard so decode can stall on pending destinations. Sits between execute/memory and the register file; decode queries its scoreboard.

## Interface
- `XLEN`, 32, data width.
- `FIFO_DEPTH`, 4, memory-result buffer entries; power of two, ≥2.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`  in  1  memory result offered.
- `mem_ready`  out  1  FIFO can accept; transfer when `mem_valid && mem_ready`.
- `mem_rd`  in  5  memory destination.
- `mem_data`  in  XLEN  memory result.
- `issue_valid`  in  1  decode issues a long-latency op.
- `issue_rd`  in  5  its destination; marks it busy.
- `issue_ready`  out  1  `~busy[issue_rd]`; issue only honoured when high.
- `rs1`, `rs2`  in  5 each  decode source indices.
- `rs1_busy`, `rs2_busy`  out  1 each  combinational `busy[rsN]`.
- `reg_write`  out  1  register file write enable (registered).
- `rd`  out  5  register file write index (registered).
- `write_data`  out  XLEN  register file write data (registered).

## Operation
- Arbitration per cycle, fixed priority: (1) `alu_valid`, (2) FIFO head if non-empty, (3) idle.
- Selected result registered into `rd`/`write_data`; `reg_write` = 1 only if selected `rd != 0`. Result to x0 is consumed (FIFO pops) with `reg_write` = 0.
- FIFO head never pops while `alu_valid` = 1; the pipeline provides ALU bubbles, no anti-starvation logic.
- `mem_ready` = FIFO count < `FIFO_DEPTH` (registered count, no same-cycle pop credit). Push when full is impossible.
- Simultaneous push and pop: count unchanged, pointers wrap modulo `FIFO_DEPTH`.
- Scoreboard: 32 busy bits, bit 0 hard-wired 0.
  - Set: `issue_valid && issue_ready && issue_rd != 0`.
  - Clear: at the clock edge ending a cycle in which `reg_write` = 1 and that write originated from the FIFO (internal `wb_from_mem` flop), index `rd`. The register file has captured the value at that same edge.
  - Set and clear of the same index on the same edge: set wins.
- ALU writes never touch the scoreboard.

## Timing
- Reset: `reg_write` = 0, `rd` = 0, `write_data` = 0, FIFO empty, `mem_ready` = 1, all busy = 0, `issue_ready` = 1. Reset mid-operation discards FIFO contents and clears the scoreboard.
- ALU result: accepted cycle N → `reg_write` high cycle N+1 → register file updated at end of N+1.
- Memory result into empty FIFO with no ALU traffic: pushed at end of N; popped in cycle N+1; `reg_write` high in cycle N+2; busy bit low from cycle N+3.
- `rs*_busy` and `issue_ready` are combinational from the busy flops; there is no same-cycle bypass of a set.

## Configuration
- `WB_FORWARD_EN` defined: adds outputs `fwd1_hit`, `fwd1_data`, `fwd2_hit`, and `fwd2_data`. `fwdN_hit` = `reg_write && rd == rsN && rd != 0`, and `fwdN_data` = `write_data`. This gives decode the value being written this cycle. The busy bit is also masked, so `rsN_busy` = `busy[rsN] && !fwdN_hit`.
- Not defined: ports absent; `rsN_busy` = `busy[rsN]`.

## Test plan
- Reset: assert `rst` mid-traffic with 3 FIFO entries → next cycle `reg_write` = 0, `mem_ready` = 1, `rs1_busy` = 0 for all indices; no stale writes afterward.
- ALU path: `alu_valid`, `alu_rd` = 5, `alu_data` = 0xDEADBEEF in cycle N → cycle N+1 `reg_write` = 1, `rd` = 5, `write_data` = 0xDEADBEEF.
- Priority/fill: `alu_valid` held 6 cycles while 4 memory results arrive → `mem_ready` drops after 4th; writes drain in FIFO order (x10..x13) once `alu_valid` falls.
- Scoreboard: issue x7; `rs1` = 7 → `rs1_busy` = 1 and `issue_ready` = 0 for x7; memory result x7 = 0x1234 → busy clears the cycle after `reg_write` = 1, `rd` = 7.
- x0 and collision: memory result to x0 → pops, `reg_write` stays 0. Issue x9 on the same edge its old write clears → x9 remains busy.
- `WB_FORWARD_EN`: while `reg_write` = 1, `rd` = 7, `write_data` = 0x1234, drive `rs2` = 7 → `fwd2_hit` = 1, `fwd2_data` = 0x1234, `rs2_busy` = 0.
